crossbar_scheduler_4bit: RTL

CROSSBAR_SCHEDULER_4BIT -- requirements
Module: crossbar_scheduler_4bit

---
 rtl/crossbar_scheduler_4bit_pkg.sv | 20 ++
 rtl/xbar_in_fifo.sv | 55 +++++
 rtl/crossbar_scheduler_4bit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/crossbar_scheduler_4bit_pkg.sv
// Shared constants and types for the 2x2 4-bit crossbar scheduler.
package crossbar_scheduler_4bit_pkg;

   localparam int unsigned W = 4;

   // Destination encoding carried with every queued word.
   localparam logic DEST_OUT1 = 1'b0;
   localparam logic DEST_OUT2 = 1'b1;

   // Crossbar select encoding.
   localparam logic CTRL_STRAIGHT = 1'b0;
   localparam logic CTRL_SWAP     = 1'b1;

   // Queue entry: destination in the MSB, data below it.
   typedef struct packed {
      logic         dest;
      logic [W-1:0] data;
   } xbar_word_t;

endpackage

// File: rtl/xbar_in_fifo.sv
// Per-port input queue: registered full/empty, no write-to-read bypass.
module xbar_in_fifo
   import crossbar_scheduler_4bit_pkg::*;
#(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wvalid_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             wready_o,
   output logic             rvalid_o,
   output logic [WIDTH-1:0] rdata_o,
   input  logic             rpop_i
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      cnt_q;
   logic             push, pop;

   assign wready_o = (cnt_q != (AW+1)'(DEPTH));
   assign rvalid_o = (cnt_q != '0);
   assign rdata_o  = mem_q[rptr_q];
   assign push     = wvalid_i && wready_o;
   assign pop      = rpop_i && rvalid_o;

   // Storage array; contents are don't-care while the queue is empty.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/crossbar_scheduler_4bit.sv
// Two input queues feeding a 2x2 crossbar; schedules heads each cycle with
// round-robin arbitration on destination conflicts.
module crossbar_scheduler_4bit
   import crossbar_scheduler_4bit_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned W          = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in1_data,
   input  logic [W-1:0] in2_data,
   input  logic         in1_dest,
   input  logic         in2_dest,
   input  logic         in1_valid,
   input  logic         in2_valid,
   output logic         in1_ready,
   output logic         in2_ready,
   output logic [W-1:0] xbar_in1,
   output logic [W-1:0] xbar_in2,
   output logic         control,
   output logic         out1_valid,
   output logic         out2_valid,
   output logic [7:0]   conflict_cnt
);

   localparam int unsigned QW = W + 1;

   xbar_word_t   head1, head2;
   logic         h1_valid, h2_valid;
   logic         pop1, pop2;
   logic         conflict, grant1, grant2;

   logic         control_q, control_d;
   logic [W-1:0] x1_q, x1_d, x2_q, x2_d;
   logic         v1_q, v1_d, v2_q, v2_d;
   logic         rr_q, rr_d;
   logic [7:0]   cnt_q, cnt_d;

   xbar_in_fifo #(
      .WIDTH(QW),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo1 (
      .clk_i   (clk),
      .rst_i   (rst),
      .wvalid_i(in1_valid),
      .wdata_i ({in1_dest, in1_data}),
      .wready_o(in1_ready),
      .rvalid_o(h1_valid),
      .rdata_o (head1),
      .rpop_i  (pop1)
   );

   xbar_in_fifo #(
      .WIDTH(QW),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo2 (
      .clk_i   (clk),
      .rst_i   (rst),
      .wvalid_i(in2_valid),
      .wdata_i ({in2_dest, in2_data}),
      .wready_o(in2_ready),
      .rvalid_o(h2_valid),
      .rdata_o (head2),
      .rpop_i  (pop2)
   );

   // Pick which heads leave this cycle and what the crossbar sees next.
   always_comb begin
      pop1      = 1'b0;
      pop2      = 1'b0;
      x1_d      = '0;
      x2_d      = '0;
      v1_d      = 1'b0;
      v2_d      = 1'b0;
      control_d = control_q;
      rr_d      = rr_q;
      cnt_d     = cnt_q;
      conflict  = h1_valid && h2_valid && (head1.dest == head2.dest);
      grant1    = h1_valid && (!h2_valid || (conflict && !rr_q));
      grant2    = h2_valid && (!h1_valid || (conflict && rr_q));

      if (h1_valid && h2_valid && !conflict) begin
         pop1      = 1'b1;
         pop2      = 1'b1;
         control_d = (head1.dest == DEST_OUT2) ? CTRL_SWAP : CTRL_STRAIGHT;
         x1_d      = head1.data;
         x2_d      = head2.data;
         v1_d      = 1'b1;
         v2_d      = 1'b1;
      end else if (grant1) begin
         pop1      = 1'b1;
         control_d = (head1.dest == DEST_OUT2) ? CTRL_SWAP : CTRL_STRAIGHT;
         x1_d      = head1.data;
         v1_d      = (head1.dest == DEST_OUT1);
         v2_d      = (head1.dest == DEST_OUT2);
      end else if (grant2) begin
         pop2      = 1'b1;
         control_d = (head2.dest == DEST_OUT2) ? CTRL_STRAIGHT : CTRL_SWAP;
         x2_d      = head2.data;
         v1_d      = (head2.dest == DEST_OUT1);
         v2_d      = (head2.dest == DEST_OUT2);
      end

      if (conflict) begin
         rr_d = !rr_q;
         if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
   end

   // Output and arbitration registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         control_q <= CTRL_STRAIGHT;
         x1_q      <= '0;
         x2_q      <= '0;
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         rr_q      <= 1'b0;
         cnt_q     <= '0;
      end else begin
         control_q <= control_d;
         x1_q      <= x1_d;
         x2_q      <= x2_d;
         v1_q      <= v1_d;
         v2_q      <= v2_d;
         rr_q      <= rr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign control      = control_q;
   assign xbar_in1     = x1_q;
   assign xbar_in2     = x2_q;
   assign out1_valid   = v1_q;
   assign out2_valid   = v2_q;
   assign conflict_cnt = cnt_q;

endmodule
